// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, decoded functions, operator/state enums and scale for the calculator
package calc_pkg;

    localparam int CALC_SCALE     = 100;
    localparam int MAX_INT_DIGITS = 7;

    localparam logic [3:0] KEY_9       = 4'h9;
    localparam logic [3:0] KEY_ADD_DIV = 4'hA;
    localparam logic [3:0] KEY_SUB_DEC = 4'hB;
    localparam logic [3:0] KEY_MUL_NEG = 4'hC;
    localparam logic [3:0] KEY_EQUAL   = 4'hD;
    localparam logic [3:0] KEY_CLEAR   = 4'hE;
    localparam logic [3:0] KEY_TOGGLE  = 4'hF;

    typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    typedef enum logic [1:0] {S_A, S_B, S_RES, S_ERR} state_e;

    typedef enum logic [3:0] {
        F_DIGIT, F_ADD, F_SUB, F_MUL, F_DIV, F_DEC, F_NEG,
        F_EQUAL, F_CLEAR, F_TOGGLE, F_MSTORE, F_MCLEAR, F_MLOAD
    } func_e;

    // The shifted layer only redefines A-F; digits mean the same in both layers.
    function automatic func_e decode_key(input logic [3:0] key, input logic shifted);
        func_e f;
        f = F_DIGIT;
        case (key)
            KEY_ADD_DIV: f = shifted ? F_DIV    : F_ADD;
            KEY_SUB_DEC: f = shifted ? F_DEC    : F_SUB;
            KEY_MUL_NEG: f = shifted ? F_NEG    : F_MUL;
            KEY_EQUAL:   f = shifted ? F_MSTORE : F_EQUAL;
            KEY_CLEAR:   f = shifted ? F_MCLEAR : F_CLEAR;
            KEY_TOGGLE:  f = shifted ? F_MLOAD  : F_TOGGLE;
            default:     f = F_DIGIT;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational signed fixed-point add/sub/mul/div with divide-by-zero flag
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SCALE  = CALC_SCALE
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  op_e                      op,
    output logic signed [DATA_W-1:0] result,
    output logic                     div_by_zero
);

    localparam int W2 = 2 * DATA_W;

    logic signed [W2-1:0] wa;
    logic signed [W2-1:0] wb;
    logic signed [W2-1:0] scale_w;
    logic signed [W2-1:0] b_safe;
    logic signed [W2-1:0] wide;

    // Double-width intermediates keep the scale correction exact; SV signed
    // division already truncates toward zero.
    always_comb begin
        wa          = {{DATA_W{a[DATA_W-1]}}, a};
        wb          = {{DATA_W{b[DATA_W-1]}}, b};
        scale_w     = W2'(SCALE);
        div_by_zero = (op == OP_DIV) && (b == '0);
        b_safe      = div_by_zero ? W2'(1) : wb;
        case (op)
            OP_ADD:  wide = wa + wb;
            OP_SUB:  wide = wa - wb;
            OP_MUL:  wide = (wa * wb) / scale_w;
            OP_DIV:  wide = (wa * scale_w) / b_safe;
            default: wide = wa;
        endcase
        result = DATA_W'(wide);
    end

endmodule

// File: rtl/calc_control_unit.sv
// rtl/calc_control_unit.sv - keypad calculator controller; CALC_MEMORY_EN enables the memory register
module calc_control_unit
    import calc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SCALE  = CALC_SCALE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        button,
    input  logic              is_pressed_next,
    output logic [DATA_W-1:0] display,
    output logic              shift_active,
    output logic              error
);

    localparam logic [DATA_W-1:0] TEN     = DATA_W'(10);
    localparam logic [DATA_W-1:0] SCALE_V = DATA_W'(SCALE);

    state_e                   state_q,   state_d;
    op_e                      op_q,      op_d;
    logic signed [DATA_W-1:0] a_q,       a_d;
    logic signed [DATA_W-1:0] b_q,       b_d;
    logic signed [DATA_W-1:0] res_q,     res_d;
    logic        [DATA_W-1:0] cur_mag_q, cur_mag_d;
    logic                     cur_neg_q, cur_neg_d;
    logic        [2:0]        int_cnt_q, int_cnt_d;
    logic        [1:0]        frac_q,    frac_d;
    logic                     has_dig_q, has_dig_d;
    logic                     shift_q,   shift_d;
    logic                     strobe_q;
`ifdef CALC_MEMORY_EN
    logic signed [DATA_W-1:0] mem_q,     mem_d;
    logic        [DATA_W-1:0] mem_abs;
`endif

    logic                     press;
    func_e                    func;
    op_e                      key_op;
    logic        [DATA_W-1:0] digit;
    logic        [DATA_W-1:0] base_mag,  dig_mag;
    logic        [2:0]        base_cnt,  dig_cnt;
    logic        [1:0]        base_frac, dig_frac;
    logic                     base_neg;
    logic signed [DATA_W-1:0] dig_val;
    logic signed [DATA_W-1:0] alu_res;
    logic                     alu_dz;
    logic                     clr_entry;

    assign press = is_pressed_next && !strobe_q;
    assign func  = decode_key(button, shift_q);
    assign digit = DATA_W'(button);

    calc_alu #(
        .DATA_W (DATA_W),
        .SCALE  (SCALE)
    ) u_alu (
        .a           (a_q),
        .b           (b_q),
        .op          (op_q),
        .result      (alu_res),
        .div_by_zero (alu_dz)
    );

    always_comb begin
        case (func)
            F_ADD:   key_op = OP_ADD;
            F_SUB:   key_op = OP_SUB;
            F_MUL:   key_op = OP_MUL;
            default: key_op = OP_DIV;
        endcase
    end

    // Operand entry works on magnitude plus sign; a digit in S_RES starts a fresh A.
    always_comb begin
        base_mag  = cur_mag_q;
        base_cnt  = int_cnt_q;
        base_frac = frac_q;
        base_neg  = cur_neg_q;
        if (state_q == S_RES) begin
            base_mag  = '0;
            base_cnt  = '0;
            base_frac = '0;
            base_neg  = 1'b0;
        end
        dig_mag  = base_mag;
        dig_cnt  = base_cnt;
        dig_frac = base_frac;
        case (base_frac)
            2'd0: if (base_cnt < 3'(MAX_INT_DIGITS)) begin
                dig_mag = base_mag * TEN + digit * SCALE_V;
                dig_cnt = base_cnt + 3'd1;
            end
            2'd1: begin
                dig_mag  = base_mag + digit * TEN;
                dig_frac = 2'd2;
            end
            2'd2: begin
                dig_mag  = base_mag + digit;
                dig_frac = 2'd3;
            end
            default: ;
        endcase
        dig_val = base_neg ? -$signed(dig_mag) : $signed(dig_mag);
    end

`ifdef CALC_MEMORY_EN
    assign mem_abs = mem_q[DATA_W-1] ? DATA_W'(-mem_q) : DATA_W'(mem_q);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_A;
            op_q      <= OP_NONE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cur_mag_q <= '0;
            cur_neg_q <= 1'b0;
            int_cnt_q <= '0;
            frac_q    <= '0;
            has_dig_q <= 1'b0;
            shift_q   <= 1'b0;
            strobe_q  <= 1'b0;
`ifdef CALC_MEMORY_EN
            mem_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            cur_mag_q <= cur_mag_d;
            cur_neg_q <= cur_neg_d;
            int_cnt_q <= int_cnt_d;
            frac_q    <= frac_d;
            has_dig_q <= has_dig_d;
            shift_q   <= shift_d;
            strobe_q  <= is_pressed_next;
`ifdef CALC_MEMORY_EN
            mem_q     <= mem_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cur_mag_d = cur_mag_q;
        cur_neg_d = cur_neg_q;
        int_cnt_d = int_cnt_q;
        frac_d    = frac_q;
        has_dig_d = has_dig_q;
        shift_d   = shift_q;
        clr_entry = 1'b0;
`ifdef CALC_MEMORY_EN
        mem_d     = mem_q;
`endif
        if (press) begin
            shift_d = 1'b0;
            if (state_q == S_ERR) begin
                if (func == F_CLEAR) begin
                    state_d   = S_A;
                    op_d      = OP_NONE;
                    a_d       = '0;
                    res_d     = '0;
                    clr_entry = 1'b1;
                end
            end else begin
                case (func)
                    F_DIGIT: begin
                        cur_mag_d = dig_mag;
                        cur_neg_d = base_neg;
                        int_cnt_d = dig_cnt;
                        frac_d    = dig_frac;
                        has_dig_d = 1'b1;
                        if (state_q == S_B) begin
                            b_d = dig_val;
                        end else begin
                            a_d     = dig_val;
                            state_d = S_A;
                        end
                    end
                    F_DEC: begin
                        if (state_q != S_RES && frac_q == 2'd0) frac_d = 2'd1;
                    end
                    F_NEG: begin
                        case (state_q)
                            S_A:     begin a_d = -a_q; cur_neg_d = !cur_neg_q; end
                            S_B:     begin b_d = -b_q; cur_neg_d = !cur_neg_q; end
                            default: res_d = -res_q;
                        endcase
                    end
                    F_ADD, F_SUB, F_MUL, F_DIV: begin
                        if (state_q == S_B && has_dig_q) begin
                            if (alu_dz) begin
                                state_d = S_ERR;
                            end else begin
                                a_d       = alu_res;
                                op_d      = key_op;
                                clr_entry = 1'b1;
                            end
                        end else if (state_q == S_B) begin
                            op_d = key_op;
                        end else begin
                            if (state_q == S_RES) a_d = res_q;
                            op_d      = key_op;
                            state_d   = S_B;
                            clr_entry = 1'b1;
                        end
                    end
                    F_EQUAL: begin
                        if (state_q == S_A) begin
                            res_d   = a_q;
                            state_d = S_RES;
                        end else if (state_q == S_B) begin
                            if (alu_dz) begin
                                state_d = S_ERR;
                            end else begin
                                res_d   = alu_res;
                                state_d = S_RES;
                            end
                        end
                    end
                    F_CLEAR: begin
                        state_d   = S_A;
                        op_d      = OP_NONE;
                        a_d       = '0;
                        res_d     = '0;
                        clr_entry = 1'b1;
                    end
                    F_TOGGLE: shift_d = 1'b1;
                    F_MSTORE, F_MCLEAR, F_MLOAD: begin
`ifdef CALC_MEMORY_EN
                        if (func == F_MSTORE) begin
                            mem_d = display;
                        end else if (func == F_MCLEAR) begin
                            mem_d = '0;
                        end else if (state_q == S_RES) begin
                            res_d = mem_q;
                        end else begin
                            // Loaded value counts as a complete entry; further digits are ignored.
                            if (state_q == S_B) b_d = mem_q;
                            else                a_d = mem_q;
                            cur_mag_d = mem_abs;
                            cur_neg_d = mem_q[DATA_W-1];
                            int_cnt_d = 3'(MAX_INT_DIGITS);
                            frac_d    = 2'd3;
                            has_dig_d = 1'b1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
            if (clr_entry) begin
                b_d       = '0;
                cur_mag_d = '0;
                cur_neg_d = 1'b0;
                int_cnt_d = '0;
                frac_d    = '0;
                has_dig_d = 1'b0;
            end
        end
    end

    always_comb begin
        case (state_q)
            S_A:     display = a_q;
            S_B:     display = has_dig_q ? b_q : a_q;
            S_RES:   display = res_q;
            default: display = '0;
        endcase
        shift_active = shift_q;
        error        = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_calc_control_unit.sv
// tb/tb_calc_control_unit.sv - directed key sequences against hand-computed displays
module tb_calc_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  button = 4'h0;
    logic        is_pressed_next = 1'b0;
    logic [31:0] display;
    logic        shift_active;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    calc_control_unit dut (
        .clock           (clock),
        .reset           (reset),
        .button          (button),
        .is_pressed_next (is_pressed_next),
        .display         (display),
        .shift_active    (shift_active),
        .error           (error)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Strobe is held for two edges so a repeat would be visible.
    task automatic press(input logic [3:0] k);
        @(negedge clock);
        button          = k;
        is_pressed_next = 1'b1;
        @(negedge clock);
        @(negedge clock);
        is_pressed_next = 1'b0;
        @(negedge clock);
    endtask

    task automatic enter(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            case (c)
                "+": press(4'hA);
                "-": press(4'hB);
                "*": press(4'hC);
                "=": press(4'hD);
                "E": press(4'hE);
                "T": press(4'hF);
                "/": begin press(4'hF); press(4'hA); end
                ".": begin press(4'hF); press(4'hB); end
                "N": begin press(4'hF); press(4'hC); end
                "S": begin press(4'hF); press(4'hD); end
                "Z": begin press(4'hF); press(4'hE); end
                "L": begin press(4'hF); press(4'hF); end
                default: press(4'(c - 8'd48));
            endcase
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_val("reset_display", display, 0);
        check_val("reset_shift", {31'd0, shift_active}, 0);
        check_val("reset_error", {31'd0, error}, 0);
        reset = 1'b1;

        enter("9+");
        check_val("show_a_in_b", display, 900);
        enter("7");
        check_val("show_b_digit", display, 700);
        enter("=");
        check_val("add_9_7", display, 1600);

        enter("E9+7T");
        check_val("shift_armed", {31'd0, shift_active}, 1);
        enter("*");
        check_val("shift_cleared", {31'd0, shift_active}, 0);
        enter("=");
        check_val("add_neg7", display, 200);

        enter("E9N*7=");
        check_val("mul_neg9_7", display, -6300);
        enter("E5.09*1.25=");
        check_val("mul_frac", display, 636);
        enter("EN5.09/1.25=");
        check_val("div_neg_frac", display, -407);
        enter("E.09+4.93=");
        check_val("add_frac", display, 502);
        enter("-5.01=");
        check_val("chain_from_res", display, 1);

        enter("E12345678");
        check_val("int_digit_limit", display, 123456700);
        enter("E1.234");
        check_val("frac_digit_limit", display, 123);
        enter("E2+3*4=");
        check_val("chain_ops", display, 2000);
        enter("E6+*2=");
        check_val("replace_op", display, 1200);
        enter("E8=");
        check_val("equal_in_a", display, 800);

        enter("E5+3=S");
        check_val("store_display", display, 800);
        check_val("store_shift", {31'd0, shift_active}, 0);
        enter("E2+5=");
        check_val("mem_between", display, 700);
        enter("EL+4=");
`ifdef CALC_MEMORY_EN
        check_val("mem_load", display, 1200);
`else
        check_val("mem_load", display, 400);
`endif
        enter("EZL+4=");
        check_val("mem_clear_load", display, 400);

        enter("E9/0=");
        check_val("div0_error", {31'd0, error}, 1);
        check_val("div0_display", display, 0);
        enter("5+");
        check_val("err_ignores_keys", display, 0);
        check_val("err_stays", {31'd0, error}, 1);
        enter("E");
        check_val("clear_error", {31'd0, error}, 0);
        check_val("clear_display", display, 0);

        enter("9+");
        #2 reset = 1'b0;
        #1;
        check_val("async_rst_display", display, 0);
        check_val("async_rst_error", {31'd0, error}, 0);
        @(negedge clock);
        reset = 1'b1;
        enter("7=");
        check_val("after_reset", display, 700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
